// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard scheduler for a 3-stage pipeline (fetch -> decode/reg-read ->
//   execute/write-back). It watches the decode and execute stage registers
//   and drives the per-stage hold/flush controls:
//     - stalls fetch/decode on read-after-write and load-use hazards
//     - flushes wrong-path instructions when execute loads the PC
//   It also keeps saturating stall/flush event counters for debug.
//
// Parameters
//   FLUSH_CYCLES  cycles flush stays asserted after a PC load (1..3)
//   LOAD_STALL    stall cycles for a load-use hazard (1..3)
//   CNT_W         width of the stall_cnt / flush_cnt event counters
//
// Ports
//   clk         in   pipeline clock, all state updates on posedge
//   rst         in   synchronous reset, active-high
//   id_rd_en    in   decode-stage instruction reads a register
//   id_rd_addr  in   register index read in decode
//   ex_we       in   execute-stage instruction writes the register file
//   ex_wr_addr  in   register index written in execute
//   ex_is_load  in   execute-stage instruction is LDA_rn / POP_rn
//   ex_l_pc     in   execute stage loads the PC
//   hold_if     out  hold PC and the fetch-stage register
//   hold_id     out  hold the decode-stage register
//   bubble_ex   out  load NOP into the execute-stage register
//   flush       out  force fetch/decode opcodes to NOP on next edge
//   busy        out  state != RUN
//   stall_cnt   out  stall cycles since reset (saturating)
//   flush_cnt   out  flush cycles since reset (saturating)

module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LOAD_STALL   = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rd_en,
    input  logic [2:0]       id_rd_addr,
    input  logic             ex_we,
    input  logic [2:0]       ex_wr_addr,
    input  logic             ex_is_load,
    input  logic             ex_l_pc,
    output logic             hold_if,
    output logic             hold_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LEFT = 2'(FLUSH_CYCLES - 1);
    localparam logic [1:0] STALL_LEFT = 2'(LOAD_STALL - 1);

    state_t     state, state_n;
    logic [1:0] left, left_n;
    logic       raw;
    logic       stall_c;
    logic       flush_c;

    always_comb begin
        state_n = state;
        left_n  = left;
        stall_c = 1'b0;
        flush_c = 1'b0;
        raw     = id_rd_en & ex_we & (id_rd_addr == ex_wr_addr);

        unique case (state)
            RUN: begin
                // PC load has priority: wrong-path instructions would be
                // discarded anyway, so stalling them is pointless.
                if (ex_l_pc) begin
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = FLUSH;
                        left_n  = FLUSH_LEFT;
                    end
                end else if (raw) begin
                    stall_c = 1'b1;
                    if (ex_is_load && (LOAD_STALL > 1)) begin
                        state_n = STALL;
                        left_n  = STALL_LEFT;
                    end
                end
            end
            STALL: begin
                // Execute holds a bubble here, so ex_l_pc cannot be genuine.
                stall_c = 1'b1;
                if (left <= 2'd1) begin
                    state_n = RUN;
                    left_n  = '0;
                end else begin
                    left_n = left - 2'd1;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (ex_l_pc) begin
                    left_n = FLUSH_LEFT;
                end else if (left <= 2'd1) begin
                    state_n = RUN;
                    left_n  = '0;
                end else begin
                    left_n = left - 2'd1;
                end
            end
            default: begin
                state_n = RUN;
                left_n  = '0;
            end
        endcase
    end

    // Outputs are forced low while rst is held so that arbitrary stage
    // contents during reset never reach the pipeline controls.
    assign hold_if   = stall_c & ~rst;
    assign hold_id   = stall_c & ~rst;
    assign bubble_ex = stall_c & ~rst;
    assign flush     = flush_c & ~rst;
    assign busy      = (state != RUN) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            left      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            left  <= left_n;
            if (hold_if && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_rd_en;
    logic [2:0]  id_rd_addr;
    logic        ex_we;
    logic [2:0]  ex_wr_addr;
    logic        ex_is_load;
    logic        ex_l_pc;

    logic        hold_if, hold_id, bubble_ex, flush, busy;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_hold_if, s_hold_id, s_bubble_ex, s_flush, s_busy;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
        .ex_we(ex_we), .ex_wr_addr(ex_wr_addr),
        .ex_is_load(ex_is_load), .ex_l_pc(ex_l_pc),
        .hold_if(hold_if), .hold_id(hold_id), .bubble_ex(bubble_ex),
        .flush(flush), .busy(busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
        .ex_we(ex_we), .ex_wr_addr(ex_wr_addr),
        .ex_is_load(ex_is_load), .ex_l_pc(ex_l_pc),
        .hold_if(s_hold_if), .hold_id(s_hold_id), .bubble_ex(s_bubble_ex),
        .flush(s_flush), .busy(s_busy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // {hold_if, hold_id, bubble_ex, flush, busy}
    logic [4:0] ctrl;
    assign ctrl = {hold_if, hold_id, bubble_ex, flush, busy};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rd_en = 1'b0; id_rd_addr = 3'd0;
        ex_we = 1'b0; ex_wr_addr = 3'd0;
        ex_is_load = 1'b0; ex_l_pc = 1'b0;
    endtask

    // advance one clock edge; inputs change 1 time unit after posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sample combinational outputs mid-cycle
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        id_rd_en = 1'b1; id_rd_addr = 3'd6;
        ex_we = 1'b1; ex_wr_addr = 3'd6;
        ex_is_load = 1'($urandom_range(0, 1));
        ex_l_pc = 1'($urandom_range(0, 1));
        step();
        id_rd_addr = 3'($urandom_range(0, 7));
        ex_wr_addr = id_rd_addr;
        ex_l_pc = 1'($urandom_range(0, 1));
        step();
        sample();
        chk("reset_ctrl", 16'(ctrl), 16'h0);
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        chk("reset_flush_cnt", flush_cnt, 16'd0);

        // ---------------- non-hazards ----------------
        step();
        rst = 1'b0;
        idle_inputs();
        id_rd_en = 1'b1; id_rd_addr = 3'd4; ex_we = 1'b1; ex_wr_addr = 3'd3;
        sample();
        chk("addr_mismatch_ctrl", 16'(ctrl), 16'h00);
        id_rd_en = 1'b0; id_rd_addr = 3'd3;
        #1;
        chk("rd_en_low_ctrl", 16'(ctrl), 16'h00);

        // ---------------- ALU RAW: single-cycle stall ----------------
        step();
        id_rd_en = 1'b1; id_rd_addr = 3'd3; ex_we = 1'b1; ex_wr_addr = 3'd3;
        sample();
        chk("alu_raw_ctrl", 16'(ctrl), 16'b11100);
        step();
        idle_inputs();
        sample();
        chk("alu_raw_after_ctrl", 16'(ctrl), 16'h00);
        chk("alu_raw_stall_cnt", stall_cnt, 16'd1);

        // ---------------- load-use: 2 stall cycles ----------------
        step();
        id_rd_en = 1'b1; id_rd_addr = 3'd5; ex_we = 1'b1; ex_wr_addr = 3'd5;
        ex_is_load = 1'b1;
        sample();
        chk("load_c1_ctrl", 16'(ctrl), 16'b11100);
        step();
        idle_inputs();
        ex_l_pc = 1'b1;  // ignored while stalled
        sample();
        chk("load_c2_ctrl", 16'(ctrl), 16'b11101);
        chk("load_c2_stall_cnt", stall_cnt, 16'd2);
        step();
        idle_inputs();
        sample();
        chk("load_done_ctrl", 16'(ctrl), 16'h00);
        chk("load_done_stall_cnt", stall_cnt, 16'd3);
        chk("load_done_flush_cnt", flush_cnt, 16'd0);

        // ---------------- taken jump: 2 flush cycles ----------------
        step();
        ex_l_pc = 1'b1;
        sample();
        chk("jump_c1_ctrl", 16'(ctrl), 16'b00010);
        step();
        idle_inputs();
        sample();
        chk("jump_c2_ctrl", 16'(ctrl), 16'b00011);
        chk("jump_c2_flush_cnt", flush_cnt, 16'd1);
        step();
        sample();
        chk("jump_done_ctrl", 16'(ctrl), 16'h00);
        chk("jump_done_flush_cnt", flush_cnt, 16'd2);

        // ---------------- flush beats stall, then restart ----------------
        step();
        ex_l_pc = 1'b1;
        id_rd_en = 1'b1; id_rd_addr = 3'd2; ex_we = 1'b1; ex_wr_addr = 3'd2;
        sample();
        chk("simul_c1_ctrl", 16'(ctrl), 16'b00010);
        step();
        idle_inputs();
        ex_l_pc = 1'b1;
        sample();
        chk("simul_c2_ctrl", 16'(ctrl), 16'b00011);
        step();
        idle_inputs();
        sample();
        chk("simul_c3_ctrl", 16'(ctrl), 16'b00011);
        step();
        sample();
        chk("simul_done_ctrl", 16'(ctrl), 16'h00);
        chk("simul_flush_cnt", flush_cnt, 16'd5);
        chk("simul_stall_cnt", stall_cnt, 16'd3);

        // ---------------- saturation (CNT_W=2 copy) ----------------
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        id_rd_en = 1'b1; id_rd_addr = 3'd1; ex_we = 1'b1; ex_wr_addr = 3'd1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("sat_ctrl", 16'(ctrl), 16'b11100);
            chk("sat_cnt_progress", 16'(s_stall_cnt), (i < 3) ? 16'(i) : 16'd3);
            step();
        end
        idle_inputs();
        sample();
        chk("sat_final_narrow", 16'(s_stall_cnt), 16'd3);
        chk("sat_final_wide", stall_cnt, 16'd5);

        // ---------------- reset in the middle of STALL ----------------
        step();
        id_rd_en = 1'b1; id_rd_addr = 3'd7; ex_we = 1'b1; ex_wr_addr = 3'd7;
        ex_is_load = 1'b1;
        sample();
        chk("midrst_c1_ctrl", 16'(ctrl), 16'b11100);
        step();
        idle_inputs();
        sample();
        chk("midrst_stall_ctrl", 16'(ctrl), 16'b11101);
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("midrst_after_ctrl", 16'(ctrl), 16'h00);
        chk("midrst_stall_cnt", stall_cnt, 16'd0);
        chk("midrst_flush_cnt", flush_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time bound so the run can never hang
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
